// File: rtl/addsub_pkg.sv
// Shared types and defaults for the add/sub arbiter slice.
package addsub_pkg;

  localparam int ADDSUB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one external Add_Sub unit between two requesters, one transaction
// in flight at a time, and returns a tagged result over valid/ready.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int W = ADDSUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic         au_ci,
  input  logic [W-1:0] au_s,
  input  logic         au_cout,
  input  logic         au_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         rsp_v
);

  logic [1:0][W-1:0] w_req_a, w_req_b;
  logic [1:0]        w_req_valid, w_req_sub, w_gnt;
  logic              w_gnt_id, w_accept, w_rsp_fire;
  state_e            r_state, w_state_nxt;

  logic              r_ptr;
  logic [W-1:0]      r_a, r_b;
  logic              r_sub, r_id;
  logic              r_rsp_id, r_rsp_cout, r_rsp_v;
  logic [W-1:0]      r_rsp_s;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_req_sub   = {req1_sub, req0_sub};
  assign w_req_a     = {req1_a, req0_a};
  assign w_req_b     = {req1_b, req0_b};
  assign w_gnt_id    = w_gnt[1];

  rr_arb2 u_arb (
    .i_req (w_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_fire  = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req_valid) begin
          w_accept    = 1'b1;
          req0_ready  = w_gnt[0];
          req1_ready  = w_gnt[1];
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on grant; response capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_id       <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_s    <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_v    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_req_a[w_gnt_id];
        r_b   <= w_req_b[w_gnt_id];
        r_sub <= w_req_sub[w_gnt_id];
        r_id  <= w_gnt_id;
      end
      if (r_state == EXEC) begin
        r_rsp_id   <= r_id;
        r_rsp_s    <= au_s;
        r_rsp_cout <= au_cout;
        r_rsp_v    <= au_v;
      end
      if (w_rsp_fire) r_ptr <= ~r_rsp_id;
    end
  end

  assign au_a     = r_a;
  assign au_b     = r_b;
  assign au_ci    = r_sub;
  assign rsp_id   = r_rsp_id;
  assign rsp_s    = r_rsp_s;
  assign rsp_cout = r_rsp_cout;
  assign rsp_v    = r_rsp_v;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: plays the external Add_Sub unit and scoreboards responses.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  localparam int W = ADDSUB_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] au_a, au_b, au_s;
  logic         au_ci, au_cout, au_v;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_v;
  logic [W-1:0] rsp_s;

  typedef struct {
    bit           id;
    logic [W-1:0] s;
    logic         cout;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .au_a(au_a), .au_b(au_b), .au_ci(au_ci),
    .au_s(au_s), .au_cout(au_cout), .au_v(au_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_v(rsp_v)
  );

  // The shared Add_Sub unit as seen from outside the block.
  logic [W:0]   au_sum;
  logic [W-1:0] au_bb;
  always_comb begin
    au_bb  = au_ci ? ~au_b : au_b;
    au_sum = {1'b0, au_a} + {1'b0, au_bb} + {{W{1'b0}}, au_ci};
  end
  assign au_s    = au_sum[W-1:0];
  assign au_cout = au_sum[W];
  assign au_v    = (au_a[W-1] == au_bb[W-1]) && (au_sum[W-1] != au_a[W-1]);

  // Expected result from plain integer arithmetic.
  function automatic exp_t model(bit id, int a, int b, bit sub);
    exp_t m;
    int   sa, sbv, r, sr;
    sa  = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sbv = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    if (!sub) begin
      r = a + b;  m.cout = (r >= (1 << W)); sr = sa + sbv;
    end else begin
      r = a - b;  m.cout = (a >= b);        sr = sa - sbv;
    end
    m.id = id;
    m.s  = W'(r);
    m.v  = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected got id=%0d s=%0d, required no response", rsp_id, rsp_s);
      end else begin
        n_pass++;
        mon_e = exp_q.pop_front();
        n_total++;
        if (rsp_id !== mon_e.id) $display("FAIL rsp_id got %0d required %0d", rsp_id, mon_e.id);
        else n_pass++;
        n_total++;
        if (rsp_s !== mon_e.s) $display("FAIL rsp_s got %0d required %0d", rsp_s, mon_e.s);
        else n_pass++;
        n_total++;
        if (rsp_cout !== mon_e.cout) $display("FAIL rsp_cout got %b required %b", rsp_cout, mon_e.cout);
        else n_pass++;
        n_total++;
        if (rsp_v !== mon_e.v) $display("FAIL rsp_v got %b required %b", rsp_v, mon_e.v);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    #2;
    n_total++;
    if ({req0_ready, req1_ready, au_a, au_b, au_ci, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_v} !== '0)
      $display("FAIL reset_outputs got a=%0d b=%0d ci=%b rv=%b s=%0d, required all 0", au_a, au_b, au_ci, rsp_valid, rsp_s);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single0();
    req0_valid = 1'b1; req0_a = W'(6); req0_b = W'(5); req0_sub = 1'b0;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single0_grant got %b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(0, 6, 5, 0));
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({rsp_valid, req0_ready, req1_ready, au_a, au_b, au_ci} !== {3'b000, W'(6), W'(5), 1'b0})
      $display("FAIL single0_exec got rv=%b a=%0d b=%0d ci=%b required rv=0 a=6 b=5 ci=0", rsp_valid, au_a, au_b, au_ci);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rsp_valid !== 1'b1) $display("FAIL single0_latency got rsp_valid=%b required 1", rsp_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_single1();
    req1_valid = 1'b1; req1_a = W'(7); req1_b = W'(14); req1_sub = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL single1_grant got %b%b required 01", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(1, 7, 14, 1));
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (au_ci !== 1'b1) $display("FAIL single1_au_ci got %b required 1", au_ci);
    else n_pass++;
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_a = W'(15); req0_b = W'(15); req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = W'(3);  req1_b = W'(9);  req1_sub = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL tie1_grant got %b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(0, 15, 15, 0));
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) $display("FAIL tie_resp_ready got rv=%b %b%b required 1 00", rsp_valid, req0_ready, req1_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL tie2_grant got %b%b required 01", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(1, 3, 9, 1));
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
    req0_valid = 1'b1; req0_a = W'(1); req0_b = W'(1); req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = W'(2); req1_b = W'(2); req1_sub = 1'b0;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL tie3_grant got %b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(0, 1, 1, 0));
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = W'(11); req0_b = W'(11); req0_sub = 1'b0;
    @(negedge clk);
    exp_q.push_back(model(0, 11, 11, 0));
    tick(); req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = W'(1); req1_b = W'(2); req1_sub = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_v, req0_ready, req1_ready} !== {2'b10, W'(6), 4'b1100})
        $display("FAIL bp_hold[%0d] got rv=%b s=%0d c=%b v=%b rdy=%b%b required rv=1 s=6 c=1 v=1 rdy=00",
                 i, rsp_valid, rsp_s, rsp_cout, rsp_v, req0_ready, req1_ready);
      else n_pass++;
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (req1_ready !== 1'b0) $display("FAIL bp_no_early_accept got %b required 0", req1_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (req1_ready !== 1'b1) $display("FAIL bp_pending_accept got %b required 1", req1_ready);
    else n_pass++;
    exp_q.push_back(model(1, 1, 2, 0));
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_a = W'(4); req0_b = W'(1); req0_sub = 1'b1;
    @(negedge clk);
    exp_q.push_back(model(0, 4, 1, 1));
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
    req0_valid = 1'b1; req0_a = W'(2); req0_b = W'(8); req0_sub = 1'b0;
    @(negedge clk);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({au_a, au_b} !== {W'(2), W'(8)}) $display("FAIL rst_mid_exec got a=%0d b=%0d required a=2 b=8", au_a, au_b);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({req0_ready, req1_ready, au_a, au_b, au_ci, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_v} !== '0)
      $display("FAIL rst_mid_outputs got a=%0d b=%0d rv=%b s=%0d, required all 0", au_a, au_b, rsp_valid, rsp_s);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL rst_mid_no_rsp[%0d] got %b required 0", i, rsp_valid);
      else n_pass++;
    end
    tick();
    req0_valid = 1'b1; req0_a = W'(5); req0_b = W'(5); req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = W'(6); req1_b = W'(6); req1_sub = 1'b0;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_mid_tie got %b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    exp_q.push_back(model(0, 5, 5, 0));
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
  endtask

  task automatic test_drop();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000)
        $display("FAIL drop_idle[%0d] got rv=%b rdy=%b%b required 0 00", i, rsp_valid, req0_ready, req1_ready);
      else n_pass++;
    end
    tick();
    req1_valid = 1'b1; req1_a = W'(9); req1_b = W'(3); req1_sub = 1'b1;
    @(negedge clk);
    n_total++;
    if (req1_ready !== 1'b1) $display("FAIL drop_still_idle got req1_ready=%b required 1", req1_ready);
    else n_pass++;
    exp_q.push_back(model(1, 9, 3, 1));
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();
  endtask

  initial begin
    test_reset();
    test_single0();
    test_single1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_drop();
    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL responses_missing got %0d outstanding required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
